// File: rtl/board_io_if.sv
// Board-side signal bundle between the clock manager / board pins and the I/O controller.
// The controller attaches to the slave modport; the board side drives through master.
interface board_io_if #(
  parameter int NUM_BTN = 5,
  parameter int NUM_LED = 16
);
  logic [NUM_BTN-1:0] btn_in;
  logic               locked;
  logic [NUM_LED-1:0] led_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               core_rst;
  logic [NUM_LED-1:0] led;

  modport master (
    output btn_in, locked, led_in,
    input  btn_level, btn_press, btn_release, core_rst, led
  );

  modport slave (
    input  btn_in, locked, led_in,
    output btn_level, btn_press, btn_release, core_rst, led
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O and reset controller: button sync/debounce with edge pulses, core reset
// sequencing from lock and a reset button, and LED drive with a reset-time heartbeat.
module board_io_ctrl #(
  parameter int CLK_HZ       = 75000000,
  parameter int NUM_BTN      = 5,
  parameter int NUM_LED      = 16,
  parameter int DEBOUNCE_CYC = 750000,
  parameter int RST_BTN      = 0,
  parameter int RST_HOLD_CYC = 1024,
  parameter int HEARTBEAT_HZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  board_io_if.slave   io
);

  localparam int HB_HALF = CLK_HZ / (2 * HEARTBEAT_HZ);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W  = $clog2(RST_HOLD_CYC);
  localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_HALF - 1);

  typedef enum logic {HOLD, RUN} state_t;

  logic [NUM_BTN-1:0] btn_m, btn_s;
  logic               locked_m, locked_s;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] btn_level, btn_press, btn_release;
  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               core_rst;
  logic [HB_W-1:0]    hb_cnt;
  logic               heartbeat;
  logic [NUM_LED-1:0] led;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m    <= '0;
      btn_s    <= '0;
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      btn_m    <= io.btn_in;
      btn_s    <= btn_m;
      locked_m <= io.locked;
      locked_s <= locked_m;
    end
  end

  // A bit's level only moves after DEBOUNCE_CYC consecutive samples disagree with it;
  // the press/release pulses are registered in the same cycle the level changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]      <= '0;
          btn_level[i]   <= btn_s[i];
          btn_press[i]   <= btn_s[i];
          btn_release[i] <= ~btn_s[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    case (state_q)
      HOLD: begin
        if (locked_s && !btn_level[RST_BTN]) begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end else begin
          hold_d = '0;
        end
      end
      RUN: begin
        hold_d = '0;
        if (!locked_s || btn_press[RST_BTN]) state_d = HOLD;
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  // core_rst follows the next state so it changes on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      hold_cnt <= '0;
      core_rst <= 1'b1;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
      core_rst <= (state_d == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
      led       <= '0;
    end else begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end
      led <= core_rst ? {NUM_LED{heartbeat}} : io.led_in;
    end
  end

  assign io.btn_level   = btn_level;
  assign io.btn_press   = btn_press;
  assign io.btn_release = btn_release;
  assign io.core_rst    = core_rst;
  assign io.led         = led;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: expectations are queued when stimulus is driven
// and compared on the falling edge of the cycle they are due.
module tb_board_io_ctrl;

  localparam int NUM_BTN = 3;
  localparam int NUM_LED = 4;
  localparam int HB_HALF = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   hb_base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  board_io_if #(.NUM_BTN(NUM_BTN), .NUM_LED(NUM_LED)) bus ();

  board_io_ctrl #(
    .CLK_HZ(20), .NUM_BTN(NUM_BTN), .NUM_LED(NUM_LED), .DEBOUNCE_CYC(4),
    .RST_BTN(0), .RST_HOLD_CYC(8), .HEARTBEAT_HZ(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  // sig codes: 0 core_rst, 1 btn_level, 2 btn_press, 3 btn_release, 4 led
  typedef struct {
    int         when;
    int         sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  typedef struct {
    logic [2:0] mask;
    int         width;
    logic       accept;
  } vec_t;

  exp_t sb[$];

  function automatic void expect_at(input int off, input int sig, input logic [3:0] val,
                                    input string name);
    exp_t e;
    e.when = cyc + off;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endfunction

  // Heartbeat level just after edge y, counted from the last rst_n release.
  function automatic logic hb(input int y);
    int q;
    q = (y - hb_base) / HB_HALF;
    return q[0];
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [3:0] act;
    case (e.sig)
      0:       act = {3'b000, bus.core_rst};
      1:       act = {1'b0, bus.btn_level};
      2:       act = {1'b0, bus.btn_press};
      3:       act = {1'b0, bus.btn_release};
      default: act = bus.led;
    endcase
    n_checks++;
    if (act === e.val) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %b, required %b", e.name, cyc, act, e.val);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].when == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [2:0] b, input logic l,
                               input logic [3:0] li);
    rst_n      = r;
    bus.btn_in = b;
    bus.locked = l;
    bus.led_in = li;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // core_rst is high for offsets in [rise, fall); led shows the heartbeat one cycle later.
  task automatic rst_window(input int first, input int last, input int rise, input int fall,
                            input string tag);
    for (int off = first; off <= last; off++) begin
      logic cr, pr;
      cr = (off >= rise) && (off < fall);
      pr = (off - 1 >= rise) && (off - 1 < fall);
      expect_at(off, 0, {3'b000, cr}, $sformatf("%s_core_rst", tag));
      expect_at(off, 4, pr ? {4{hb(cyc + off - 1)}} : 4'b1010, $sformatf("%s_led", tag));
    end
  endtask

  // Button mask held for width cycles from now: edges appear 6 cycles after each input edge.
  task automatic btn_window(input logic [2:0] mask, input int width, input logic accept,
                            input int last, input string tag);
    for (int off = 1; off <= last; off++) begin
      logic [2:0] lvl, prs, rel;
      lvl = (accept && off >= 6 && off < width + 6) ? mask : 3'b000;
      prs = (accept && off == 6) ? mask : 3'b000;
      rel = (accept && off == width + 6) ? mask : 3'b000;
      expect_at(off, 1, {1'b0, lvl}, $sformatf("%s_level", tag));
      expect_at(off, 2, {1'b0, prs}, $sformatf("%s_press", tag));
      expect_at(off, 3, {1'b0, rel}, $sformatf("%s_release", tag));
    end
  endtask

  task automatic expect_reset_values(input string tag);
    expect_at(1, 0, 4'b0001, $sformatf("%s_core_rst", tag));
    expect_at(1, 1, 4'b0000, $sformatf("%s_level", tag));
    expect_at(1, 2, 4'b0000, $sformatf("%s_press", tag));
    expect_at(1, 3, 4'b0000, $sformatf("%s_release", tag));
    expect_at(1, 4, 4'b0000, $sformatf("%s_led", tag));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{3'b010, 20, 1'b1};
    vecs[1] = '{3'b100, 3, 1'b0};
    vecs[2] = '{3'b100, 1, 1'b0};
    vecs[3] = '{3'b010, 4, 1'b1};
    vecs[4] = '{3'b110, 5, 1'b1};
    vecs[5] = '{3'b100, 2, 1'b0};

    // reset state, then release with lock high
    applyStimulus(1'b0, 3'b000, 1'b1, 4'b1010);
    tick(3);
    expect_reset_values("reset");
    tick(1);
    hb_base = cyc;
    applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
    rst_window(1, 11, -100, 10, "rst_release");
    tick(12);

    // clean presses, glitches and simultaneous presses from the table
    for (int i = 0; i < 6; i++) begin
      btn_window(vecs[i].mask, vecs[i].width, vecs[i].accept, vecs[i].width + 9,
                 $sformatf("vec%0d", i));
      expect_at(1, 0, 4'b0000, $sformatf("vec%0d_core_rst", i));
      expect_at(1, 4, 4'b1010, $sformatf("vec%0d_led", i));
      applyStimulus(1'b1, vecs[i].mask, 1'b1, 4'b1010);
      tick(vecs[i].width);
      applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
      tick(10);
    end

    // reset button while running
    btn_window(3'b001, 10, 1'b1, 25, "rstbtn");
    rst_window(1, 25, 7, 24, "rstbtn");
    applyStimulus(1'b1, 3'b001, 1'b1, 4'b1010);
    tick(10);
    applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
    tick(16);

    // lock loss while running
    rst_window(1, 16, 3, 15, "lockloss");
    applyStimulus(1'b1, 3'b000, 1'b0, 4'b1010);
    tick(5);
    applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
    tick(12);

    // rst_n during a hold count (hold_cnt=5) and a btn[2] debounce count
    btn_window(3'b001, 8, 1'b1, 19, "midcnt");
    rst_window(1, 19, 7, 1000, "midcnt");
    applyStimulus(1'b1, 3'b001, 1'b1, 4'b1010);
    tick(8);
    applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
    tick(8);
    applyStimulus(1'b1, 3'b100, 1'b1, 4'b1010);
    tick(3);
    applyStimulus(1'b0, 3'b100, 1'b1, 4'b1010);
    expect_reset_values("midcnt_reset");
    tick(1);
    hb_base = cyc;
    applyStimulus(1'b1, 3'b100, 1'b1, 4'b1010);
    rst_window(1, 11, -100, 10, "restart");
    btn_window(3'b100, 12, 1'b1, 21, "restart");
    tick(12);
    applyStimulus(1'b1, 3'b000, 1'b1, 4'b1010);
    tick(12);

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: %0d expectations pending, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
